deskew_buffer: RTL and testbench

- Output-side counterpart of the input skew buffer.
- Accepts the diagonally skewed result stream leaving the systolic array: column j of result row i arrives j enable-cycles after column 0 of that row.
- Realigns each row and stores ARRAY_SIZE rows in a row store.
- The controller reads stored rows back by row pointer once the tile is complete.

---
 rtl/deskew_buffer_pkg.sv | 9 +
 rtl/deskew_buffer_delay_line.sv | 36 +++
 rtl/deskew_buffer.sv | 122 ++++++++++++
 tb/tb_deskew_buffer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deskew_buffer_pkg.sv
// Shared types for the output deskew buffer: capture-controller states.
package deskew_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } deskew_state_t;

endpackage

// File: rtl/deskew_buffer_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 degenerates to a wire.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // No storage: clock, reset and enable are intentionally unused here.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst, enable};
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_p [DEPTH];

      // Stage boundary: shift one position per enabled edge, hold on stall.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
        end else if (enable) begin
          stage_p[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
        end
      end

      assign q = stage_p[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/deskew_buffer.sv
// Realigns the diagonally skewed result stream of the systolic array into
// rows, captures one tile of ARRAY_SIZE rows and serves row reads.
module deskew_buffer
  import deskew_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in [ARRAY_SIZE],
  input  logic                         clear,
  input  logic                         read,
  input  logic [$clog2(ARRAY_SIZE)-1:0] row_ptr,
  output logic signed [DATA_WIDTH-1:0] data_out [ARRAY_SIZE],
  output logic                         out_valid,
  output logic                         full,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(ARRAY_SIZE);

  // Realigned row: column j delayed by ARRAY_SIZE-1-j enabled edges, so all
  // columns of one row line up with the delayed column-0 valid.
  logic signed [DATA_WIDTH-1:0] col_p1 [ARRAY_SIZE];
  logic                         vld_p1;

  genvar j;
  generate
    for (j = 0; j < ARRAY_SIZE; j++) begin : g_col
      logic [DATA_WIDTH-1:0] col_q;
      delay_line #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (ARRAY_SIZE-1-j)
      ) u_col (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (data_in[j]),
        .q      (col_q)
      );
      assign col_p1[j] = $signed(col_q);
    end
  endgenerate

  delay_line #(
    .WIDTH (1),
    .DEPTH (ARRAY_SIZE-1)
  ) u_vld (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (in_valid),
    .q      (vld_p1)
  );

  deskew_state_t                state;
  logic [PTR_W-1:0]             wr_ptr;
  logic signed [DATA_WIDTH-1:0] row_store [ARRAY_SIZE][ARRAY_SIZE];
  logic                         aligned_p1;
  logic                         row_wr_p1;

  // A complete row is present only on an enabled edge; clear drops it.
  assign aligned_p1 = enable & vld_p1;
  assign row_wr_p1  = aligned_p1 & ~clear & (state == FILL);

  // Stage boundary: capture controller (FILL/FULL), write pointer, flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      wr_ptr   <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= FILL;
      wr_ptr   <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (aligned_p1) begin
      case (state)
        FILL: begin
          if (wr_ptr == PTR_W'(ARRAY_SIZE-1)) begin
            wr_ptr <= '0;
            full   <= 1'b1;
            state  <= FULL;
          end else begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
        end
        FULL: overflow <= 1'b1;
        default: state <= FILL;
      endcase
    end
  end

  // Stage boundary: row store, written with the realigned row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ARRAY_SIZE; r++)
        for (int c = 0; c < ARRAY_SIZE; c++) row_store[r][c] <= '0;
    end else if (row_wr_p1) begin
      row_store[wr_ptr] <= col_p1;
    end
  end

  // Stage boundary: registered read port, independent of enable; a read on
  // the clearing edge still sees the old store because full is still high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      for (int c = 0; c < ARRAY_SIZE; c++) data_out[c] <= '0;
    end else if (read && full) begin
      out_valid <= 1'b1;
      data_out  <= row_store[row_ptr];
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deskew_buffer.sv
module tb_deskew_buffer;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              in_valid;
  logic signed [7:0] data_in [4];
  logic              clear;
  logic              read;
  logic [1:0]        row_ptr;
  logic signed [7:0] data_out [4];
  logic              out_valid;
  logic              full;
  logic              overflow;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_q [$];

  deskew_buffer #(.DATA_WIDTH(8), .ARRAY_SIZE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .clear     (clear),
    .read      (read),
    .row_ptr   (row_ptr),
    .data_out  (data_out),
    .out_valid (out_valid),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Tile element generators: 0 -> j+4i, 1 -> j-4i, 2 -> -(j+1)
  function automatic logic signed [7:0] elem(input int mode, input int i, input int j);
    case (mode)
      0:       return 8'(j + 4*i);
      1:       return 8'(j - 4*i);
      default: return 8'(-(j + 1));
    endcase
  endfunction

  function automatic logic [31:0] row_of(input int mode, input int i);
    return {elem(mode, i, 3), elem(mode, i, 2), elem(mode, i, 1), elem(mode, i, 0)};
  endfunction

  function automatic logic [31:0] pack_out();
    return {data_out[3], data_out[2], data_out[1], data_out[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input int c, input int n, input int mode);
    for (int j = 0; j < 4; j++) begin
      int i;
      i = c - j;
      data_in[j] = (i >= 0 && i < n) ? elem(mode, i, j) : 8'sd0;
    end
    in_valid = (c < n);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) data_in[j] = 8'sd0;
  endtask

  // Feed n skewed rows; records the tick count at which full first reads 1.
  task automatic feed_tile(input int mode, input int n, input bit stall,
                           input bit chk, input int exp_tick, input string name);
    int first;
    int t;
    first  = -1;
    t      = 0;
    enable = 1'b1;
    for (int c = 0; c < n + 3; c++) begin
      drive_cycle(c, n, mode);
      tick();
      t++;
      if (full === 1'b1 && first < 0) first = t;
      if (stall && c == 2) begin
        enable = 1'b0;
        tick();
        t++;
        if (full === 1'b1 && first < 0) first = t;
        enable = 1'b1;
      end
    end
    idle_inputs();
    if (chk) begin
      checks++;
      if (first !== exp_tick)
        $display("FAIL %s full_rise: got tick %0d want tick %0d", name, first, exp_tick);
    end
    if (chk && first !== exp_tick) errors++;
  endtask

  task automatic read_row(input int ptr, input bit exp_acc, input logic [31:0] exp_row,
                          input string name);
    logic [31:0] prev;
    logic [31:0] want;
    prev = pack_out();
    if (exp_acc) sb_q.push_back(exp_row);
    read    = 1'b1;
    row_ptr = 2'(ptr);
    tick();
    read = 1'b0;
    checks++;
    if (out_valid !== exp_acc) begin
      errors++;
      $display("FAIL %s out_valid: got %b want %b", name, out_valid, exp_acc);
    end
    if (out_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s data: got %h want no read", name, pack_out());
      end else begin
        want = sb_q.pop_front();
        if (pack_out() !== want) begin
          errors++;
          $display("FAIL %s data: got %h want %h", name, pack_out(), want);
        end
      end
    end else begin
      sb_q.delete();
      checks++;
      if (pack_out() !== prev) begin
        errors++;
        $display("FAIL %s held: got %h want %h", name, pack_out(), prev);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: got out_valid %b want 0", name, out_valid);
    end
  endtask

  task automatic read_tile(input int mode, input string name);
    for (int i = 0; i < 4; i++) read_row(i, 1'b1, row_of(mode, i), name);
  endtask

  task automatic check_bit(input logic got, input logic want, input string name);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; clear = 1'b0; read = 1'b0; row_ptr = 2'd0;
    idle_inputs();
    tick();
    tick();
    check_bit(full, 1'b0, "reset_full");
    check_bit(out_valid, 1'b0, "reset_out_valid");
    check_bit(overflow, 1'b0, "reset_overflow");
    checks++;
    if (pack_out() !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_out: got %h want 0", pack_out());
    end
    rst = 1'b1;
    tick();
    check_bit(full, 1'b0, "post_reset_full");
  endtask

  task automatic test_premature_read();
    read_row(0, 1'b0, 32'h0, "early_read");
  endtask

  task automatic test_full_tile();
    feed_tile(0, 4, 1'b0, 1'b1, 7, "tile");
    read_tile(0, "tile_read");
  endtask

  task automatic test_overflow();
    check_bit(overflow, 1'b0, "pre_overflow");
    feed_tile(2, 1, 1'b0, 1'b0, 0, "fifth_row");
    check_bit(overflow, 1'b1, "overflow_set");
    check_bit(full, 1'b1, "overflow_full");
    read_row(0, 1'b1, row_of(0, 0), "overflow_row0");
    read_row(3, 1'b1, row_of(0, 3), "overflow_row3");
  endtask

  task automatic test_clear();
    do_clear();
    check_bit(full, 1'b0, "clear_full");
    check_bit(overflow, 1'b0, "clear_overflow");
    read_row(1, 1'b0, 32'h0, "read_after_clear");
    feed_tile(1, 4, 1'b0, 1'b1, 7, "neg_tile");
    read_tile(1, "neg_tile_read");
  endtask

  task automatic test_stall();
    do_clear();
    feed_tile(0, 4, 1'b1, 1'b1, 8, "stall");
    read_tile(0, "stall_read");
  endtask

  task automatic test_read_with_clear();
    sb_q.push_back(row_of(0, 2));
    read = 1'b1; row_ptr = 2'd2; clear = 1'b1;
    tick();
    read = 1'b0; clear = 1'b0;
    check_bit(out_valid, 1'b1, "read_clear_valid");
    check_bit(full, 1'b0, "read_clear_full");
    checks++;
    if (sb_q.size() == 0 || pack_out() !== sb_q[0]) begin
      errors++;
      $display("FAIL read_clear_data: got %h want %h", pack_out(), row_of(0, 2));
    end
    sb_q.delete();
    tick();
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(c, 4, 1);
      tick();
    end
    #3;
    rst = 1'b0;
    #1;
    check_bit(full, 1'b0, "mid_reset_full");
    check_bit(out_valid, 1'b0, "mid_reset_out_valid");
    check_bit(overflow, 1'b0, "mid_reset_overflow");
    checks++;
    if (pack_out() !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_data_out: got %h want 0", pack_out());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 5; c < 9; c++) begin
      drive_cycle(c, 4, 1);
      tick();
    end
    idle_inputs();
    check_bit(full, 1'b0, "no_spurious_full");
    feed_tile(0, 4, 1'b0, 1'b1, 7, "after_reset_tile");
    read_tile(0, "after_reset_read");
  endtask

  task automatic test_simultaneous();
    do_clear();
    enable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      drive_cycle(c, 4, 1);
      if (c == 6) clear = 1'b1;
      tick();
      clear = 1'b0;
    end
    idle_inputs();
    check_bit(full, 1'b0, "sim_clear_full");
    feed_tile(1, 4, 1'b0, 1'b1, 7, "sim_refill");
    read_row(0, 1'b1, row_of(1, 0), "sim_row0");
    read_row(3, 1'b1, row_of(1, 3), "sim_row3");
  endtask

  initial begin
    test_reset();
    test_premature_read();
    test_full_tile();
    test_overflow();
    test_clear();
    test_stall();
    test_read_with_clear();
    test_reset_mid();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
